miner_csr: RTL

MINER_CSR -- requirements
Module: miner_csr

---
 rtl/miner_csr.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/miner_csr.sv
// miner_csr: Avalon-MM CSR block that stages hash work for a miner core and reports its results.
// Optional cycle counter at 0x18/0x19 is built when MINER_CSR_HASHRATE_EN is defined.
module miner_csr (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic         avs_readdatavalid,
    output logic         irq_out,
    output logic [255:0] m_header,
    output logic [255:0] m_difficulty,
    output logic [63:0]  m_start_nonce,
    output logic [17:0]  m_control,
    input  logic [63:0]  m_solution,
    input  logic [2:0]   m_status,
    input  logic         m_irq
);

    localparam logic [4:0]  ADDR_NONCE_LO = 5'h10;
    localparam logic [4:0]  ADDR_NONCE_HI = 5'h11;
    localparam logic [4:0]  ADDR_CONTROL  = 5'h12;
    localparam logic [4:0]  ADDR_SOL_LO   = 5'h14;
    localparam logic [4:0]  ADDR_IRQ      = 5'h16;
    localparam logic [31:0] CSR_ID        = 32'h5348_4133;

    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_RUNNING    = 2'd1;
    localparam logic [1:0]  ST_FOUND      = 2'd2;

    logic [7:0][31:0] hdr_stg_r;
    logic [7:0][31:0] dif_stg_r;
    logic [63:0]      nonce_stg_r;
    logic [31:0]      sol_snap_r;
    logic             irq_pending_r;
    logic             irq_enable_r;
    logic             m_irq_q_r;

    logic [1:0]       state_s;
    logic             wr_ctrl_s;
    logic             wr_irq_s;
    logic             commit_s;
    logic             irq_rise_s;
    logic             pending_nxt_s;
    logic             enable_nxt_s;
    logic [31:0]      rdata_s;

`ifdef MINER_CSR_HASHRATE_EN
    localparam logic [4:0]  ADDR_HASH_LO  = 5'h18;
    logic [63:0]      hash_cnt_r;
    logic [31:0]      hash_snap_r;
`endif

    // Miner state is derived from run and the match flag every cycle.
    always_comb begin
        state_s = ST_IDLE;
        if (!m_control[0]) begin
            state_s = ST_IDLE;
        end else if (m_irq) begin
            state_s = ST_FOUND;
        end else begin
            state_s = ST_RUNNING;
        end
    end

    // Strobe decode and interrupt next-state; a new rising edge beats a clear.
    always_comb begin
        wr_ctrl_s  = avs_write && (avs_address == ADDR_CONTROL);
        wr_irq_s   = avs_write && (avs_address == ADDR_IRQ);
        commit_s   = wr_ctrl_s && avs_writedata[0] && !m_control[0];
        irq_rise_s = m_irq && !m_irq_q_r;
        if (irq_rise_s) begin
            pending_nxt_s = 1'b1;
        end else if (wr_irq_s && avs_writedata[0]) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = irq_pending_r;
        end
        if (wr_irq_s) begin
            enable_nxt_s = avs_writedata[1];
        end else begin
            enable_nxt_s = irq_enable_r;
        end
    end

    // Read multiplexer over current (pre-write) register values.
    always_comb begin
        rdata_s = 32'd0;
        case (avs_address[4:3])
            2'b00: rdata_s = hdr_stg_r[avs_address[2:0]];
            2'b01: rdata_s = dif_stg_r[avs_address[2:0]];
            2'b10: begin
                case (avs_address[2:0])
                    3'd0:    rdata_s = nonce_stg_r[31:0];
                    3'd1:    rdata_s = nonce_stg_r[63:32];
                    3'd2:    rdata_s = {14'd0, m_control};
                    3'd3:    rdata_s = {26'd0, state_s, irq_pending_r, m_status};
                    3'd4:    rdata_s = m_solution[31:0];
                    3'd5:    rdata_s = sol_snap_r;
                    3'd6:    rdata_s = {30'd0, irq_enable_r, irq_pending_r};
                    3'd7:    rdata_s = CSR_ID;
                    default: rdata_s = 32'd0;
                endcase
            end
            2'b11: begin
`ifdef MINER_CSR_HASHRATE_EN
                if (avs_address[2:0] == 3'd0) begin
                    rdata_s = hash_cnt_r[31:0];
                end else if (avs_address[2:0] == 3'd1) begin
                    rdata_s = hash_snap_r;
                end else begin
                    rdata_s = 32'd0;
                end
`else
                rdata_s = 32'd0;
`endif
            end
            default: rdata_s = 32'd0;
        endcase
    end

    // Staging registers, live miner outputs and control; live values move only on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_stg_r     <= '0;
            dif_stg_r     <= '0;
            nonce_stg_r   <= 64'd0;
            m_header      <= 256'd0;
            m_difficulty  <= 256'd0;
            m_start_nonce <= 64'd0;
            m_control     <= 18'd0;
        end else if (avs_write) begin
            case (avs_address[4:3])
                2'b00: hdr_stg_r[avs_address[2:0]] <= avs_writedata;
                2'b01: dif_stg_r[avs_address[2:0]] <= avs_writedata;
                2'b10: begin
                    if (avs_address == ADDR_NONCE_LO) begin
                        nonce_stg_r[31:0] <= avs_writedata;
                    end else if (avs_address == ADDR_NONCE_HI) begin
                        nonce_stg_r[63:32] <= avs_writedata;
                    end else if (wr_ctrl_s) begin
                        m_control <= avs_writedata[17:0];
                        if (commit_s) begin
                            m_header      <= hdr_stg_r;
                            m_difficulty  <= dif_stg_r;
                            m_start_nonce <= nonce_stg_r;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered read response and solution high-word snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            avs_readdata      <= 32'd0;
            avs_readdatavalid <= 1'b0;
            sol_snap_r        <= 32'd0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rdata_s;
                if (avs_address == ADDR_SOL_LO) begin
                    sol_snap_r <= m_solution[63:32];
                end
            end else begin
                avs_readdata <= 32'd0;
            end
        end
    end

    // Interrupt edge detect, pending/enable and registered host interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_irq_q_r     <= 1'b0;
            irq_pending_r <= 1'b0;
            irq_enable_r  <= 1'b0;
            irq_out       <= 1'b0;
        end else begin
            m_irq_q_r     <= m_irq;
            irq_pending_r <= pending_nxt_s;
            irq_enable_r  <= enable_nxt_s;
            irq_out       <= pending_nxt_s & enable_nxt_s;
        end
    end

`ifdef MINER_CSR_HASHRATE_EN
    // Cycle counter: counts while RUNNING, restarts on commit, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_cnt_r  <= 64'd0;
            hash_snap_r <= 32'd0;
        end else begin
            if (commit_s) begin
                hash_cnt_r <= 64'd0;
            end else if (state_s == ST_RUNNING) begin
                hash_cnt_r <= hash_cnt_r + 64'd1;
            end
            if (avs_read && (avs_address == ADDR_HASH_LO)) begin
                hash_snap_r <= hash_cnt_r[63:32];
            end
        end
    end
`endif

endmodule
